// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bundle for the alu_mdu execute unit.
//   start/op/funct/a/b : operation request from the controller (master)
//   result/zero/done   : registered ALU result, zero flag, completion pulse
//   busy               : multiply/divide engine running, requests dropped
//   hi/lo              : HI/LO architectural registers
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             done;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, funct, a, b,
    input  result, zero, done, busy, hi, lo
  );

  modport slave (
    input  start, op, funct, a, b,
    output result, zero, done, busy, hi, lo
  );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with an iterative MIPS multiply/divide unit.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : alu_mdu_if.slave (start/op/funct/a/b in; result/zero/done/busy/hi/lo out)
// Plain ops and mfhi/mflo/mthi/mtlo complete one cycle after acceptance.
// mult/multu/div/divu run IDLE -> ITER (WIDTH cycles) -> FIX -> IDLE, with
// done pulsing the cycle after FIX.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_mdu_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_e;

  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_AND, K_OR, K_SLT,
    K_MULT, K_MULTU, K_DIV, K_DIVU,
    K_MFHI, K_MFLO, K_MTHI, K_MTLO
  } kind_e;

  state_e             state, state_nx;
  kind_e              kind;
  logic               accept, busy, last;
  logic               is_mdu, is_signed, is_div;
  logic [WIDTH-1:0]   alu_val, abs_a, abs_b;
  logic [WIDTH-1:0]   result_q, hi_q, lo_q;
  logic               zero_q, done_q;
  logic [WIDTH-1:0]   acc, q, md, addend, trial, quo_fix, rem_fix;
  logic               div_mode, neg_lo, neg_hi, div0;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     add_sum, shifted;
  logic               trial_ok;
  logic [2*WIDTH-1:0] prod_fix;

  // Operation decode
  always_comb begin
    kind = K_AND;
    case (bus.op)
      2'b00: kind = K_ADD;
      2'b01: kind = K_SUB;
      2'b10: begin
        case (bus.funct)
          6'b100000: kind = K_ADD;
          6'b100010: kind = K_SUB;
          6'b100100: kind = K_AND;
          6'b100101: kind = K_OR;
          6'b101010: kind = K_SLT;
          6'b011000: kind = K_MULT;
          6'b011001: kind = K_MULTU;
          6'b011010: kind = K_DIV;
          6'b011011: kind = K_DIVU;
          6'b010000: kind = K_MFHI;
          6'b010010: kind = K_MFLO;
          6'b010001: kind = K_MTHI;
          6'b010011: kind = K_MTLO;
          default:   kind = K_AND;
        endcase
      end
      default: kind = K_AND;
    endcase
  end

  always_comb begin
    is_mdu    = (kind == K_MULT) || (kind == K_MULTU) ||
                (kind == K_DIV)  || (kind == K_DIVU);
    is_signed = (kind == K_MULT) || (kind == K_DIV);
    is_div    = (kind == K_DIV)  || (kind == K_DIVU);
    abs_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  always_comb begin
    alu_val = '0;
    case (kind)
      K_ADD:   alu_val = bus.a + bus.b;
      K_SUB:   alu_val = bus.a - bus.b;
      K_OR:    alu_val = bus.a | bus.b;
      K_SLT:   alu_val = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      K_MFHI:  alu_val = hi_q;
      K_MFLO:  alu_val = lo_q;
      default: alu_val = bus.a & bus.b;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_mdu) state_nx = ITER;
      ITER:    if (last) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy   = (state != IDLE);
    accept = bus.start && (state == IDLE);
    last   = (cnt == CW'(WIDTH - 1));
  end

  // Engine step: shift-add multiply keeps {acc,q} as the partial product with
  // the multiplier consumed from q[0]; restoring divide shifts the dividend out
  // of q into acc (remainder) and shifts quotient bits into q.
  always_comb begin
    addend   = q[0] ? md : '0;
    add_sum  = {1'b0, acc} + {1'b0, addend};
    shifted  = {acc, q[WIDTH-1]};
    trial_ok = (shifted >= {1'b0, md});
    trial    = shifted[WIDTH-1:0] - md;
    prod_fix = neg_lo ? -{acc, q} : {acc, q};
    quo_fix  = neg_lo ? -q : q;
    rem_fix  = neg_hi ? -acc : acc;
  end

  // Datapath and architectural registers
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc      <= '0;
      q        <= '0;
      md       <= '0;
      cnt      <= '0;
      div_mode <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div0     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mdu) begin
              acc      <= '0;
              cnt      <= '0;
              div_mode <= is_div;
              md       <= is_div ? abs_b : abs_a;
              q        <= is_div ? abs_a : abs_b;
              neg_lo   <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_hi   <= is_signed && bus.a[WIDTH-1];
              div0     <= (bus.b == '0);
            end else begin
              done_q <= 1'b1;
              case (kind)
                K_MTHI:  hi_q <= bus.a;
                K_MTLO:  lo_q <= bus.a;
                default: begin
                  result_q <= alu_val;
                  zero_q   <= (alu_val == '0);
                end
              endcase
            end
          end
        end
        ITER: begin
          cnt <= cnt + CW'(1);
          if (div_mode) begin
            if (trial_ok) begin
              acc <= trial;
              q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
              acc <= shifted[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= add_sum[WIDTH:1];
            q   <= {add_sum[0], q[WIDTH-1:1]};
          end
        end
        FIX: begin
          done_q <= 1'b1;
          if (div_mode) begin
            // Divide by zero leaves acc = |a|, so rem_fix already yields a.
            lo_q <= div0 ? '1 : quo_fix;
            hi_q <= rem_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: self-checking bench for alu_mdu at WIDTH=32 and WIDTH=8,
// directed cases followed by randomized operations checked against a
// behavioural model of the instruction set.
module tb_alu_mdu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(32)) bus32();
  alu_mdu_if #(.WIDTH(8))  bus8();

  alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  alu_mdu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  int          sel;
  logic        start;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [31:0] a, b;

  assign bus32.start = start && (sel == 0);
  assign bus32.op    = op;
  assign bus32.funct = funct;
  assign bus32.a     = a;
  assign bus32.b     = b;
  assign bus8.start  = start && (sel == 1);
  assign bus8.op     = op;
  assign bus8.funct  = funct;
  assign bus8.a      = a[7:0];
  assign bus8.b      = b[7:0];

  logic [31:0] o_result, o_hi, o_lo;
  logic        o_zero, o_done, o_busy;

  always_comb begin
    if (sel == 1) begin
      o_result = {24'b0, bus8.result};
      o_hi     = {24'b0, bus8.hi};
      o_lo     = {24'b0, bus8.lo};
      o_zero   = bus8.zero;
      o_done   = bus8.done;
      o_busy   = bus8.busy;
    end else begin
      o_result = bus32.result;
      o_hi     = bus32.hi;
      o_lo     = bus32.lo;
      o_zero   = bus32.zero;
      o_done   = bus32.done;
      o_busy   = bus32.busy;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model state, indexed by DUT (0 = WIDTH 32, 1 = WIDTH 8)
  logic [31:0] m_hi[2], m_lo[2], m_res[2];

  function automatic longint sx(input int w, input logic [31:0] v);
    longint u;
    u = longint'(v);
    return v[w-1] ? u - (longint'(1) << w) : u;
  endfunction

  // 0 add 1 sub 2 and 3 or 4 slt 5 mult 6 multu 7 div 8 divu
  // 9 mfhi 10 mflo 11 mthi 12 mtlo
  function automatic int tb_kind(input logic [1:0] o, input logic [5:0] f);
    if (o == 2'b00) return 0;
    if (o == 2'b01) return 1;
    if (o == 2'b11) return 2;
    case (f)
      6'h20: return 0;
      6'h22: return 1;
      6'h24: return 2;
      6'h25: return 3;
      6'h2A: return 4;
      6'h18: return 5;
      6'h19: return 6;
      6'h1A: return 7;
      6'h1B: return 8;
      6'h10: return 9;
      6'h12: return 10;
      6'h11: return 11;
      6'h13: return 12;
      default: return 2;
    endcase
  endfunction

  task automatic ref_mdu(input int w, input int k, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] h, output logic [31:0] l);
    longint mask, ua, ub, sa, sb, p, qq, rr;
    mask = (longint'(1) << w) - 1;
    ua = longint'(av) & mask;
    ub = longint'(bv) & mask;
    sa = sx(w, av);
    sb = sx(w, bv);
    h = 0;
    l = 0;
    if (k == 5 || k == 6) begin
      p = (k == 5) ? sa * sb : ua * ub;
      h = 32'((p >> w) & mask);
      l = 32'(p & mask);
    end else if (ub == 0) begin
      l = 32'(mask);
      h = 32'(ua);
    end else if (k == 7 && sa == -(longint'(1) << (w - 1)) && sb == -1) begin
      l = 32'(ua);
      h = 0;
    end else begin
      qq = (k == 7) ? sa / sb : ua / ub;
      rr = (k == 7) ? sa % sb : ua % ub;
      l = 32'(qq & mask);
      h = 32'(rr & mask);
    end
  endtask

  // Issue one operation from an idle cycle (called at a negedge) and check it.
  // Returns at a negedge in which a new request may be accepted.
  task automatic do_op(input int s, input logic [1:0] o, input logic [5:0] f,
                       input logic [31:0] av, input logic [31:0] bv);
    int w, k, lat, bcnt;
    logic [31:0] mask, ea, eb, eh, el;
    w    = (s == 1) ? 8 : 32;
    mask = (s == 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    ea   = av & mask;
    eb   = bv & mask;
    k    = tb_kind(o, f);
    sel  = s;
    start = 1'b1; op = o; funct = f; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (k >= 5 && k <= 8) begin
      ref_mdu(w, k, ea, eb, eh, el);
      lat  = 0;
      bcnt = 0;
      for (int i = 1; i <= w + 8; i++) begin
        if (o_busy) bcnt++;
        if (o_done) begin
          lat = i;
          break;
        end
        @(negedge clk);
      end
      check("mdu_latency", 32'(lat), 32'(w + 2));
      check("mdu_busy_cycles", 32'(bcnt), 32'(w + 1));
      check("mdu_hi", o_hi, eh);
      check("mdu_lo", o_lo, el);
      check("mdu_result_kept", o_result, m_res[s]);
      m_hi[s] = eh;
      m_lo[s] = el;
    end else begin
      case (k)
        0:  m_res[s] = (ea + eb) & mask;
        1:  m_res[s] = (ea - eb) & mask;
        3:  m_res[s] = ea | eb;
        4:  m_res[s] = (sx(w, ea) < sx(w, eb)) ? 32'd1 : 32'd0;
        9:  m_res[s] = m_hi[s];
        10: m_res[s] = m_lo[s];
        11: m_hi[s] = ea;
        12: m_lo[s] = ea;
        default: m_res[s] = ea & eb;
      endcase
      check("alu_done", 32'(o_done), 32'd1);
      check("alu_result", o_result, m_res[s]);
      check("alu_zero", 32'(o_zero), (m_res[s] == 0) ? 32'd1 : 32'd0);
      check("alu_hi", o_hi, m_hi[s]);
      check("alu_lo", o_lo, m_lo[s]);
      @(negedge clk);
      check("alu_done_drop", 32'(o_done), 32'd0);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0080;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_op(input int s, input int mdu_bias);
    logic [5:0] tbl[14];
    logic [1:0] o;
    logic [5:0] f;
    int r;
    tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h19,
            6'h1A, 6'h1B, 6'h10, 6'h12, 6'h11, 6'h13, 6'h07};
    o = 2'b10;
    f = tbl[$urandom_range(0, 13)];
    r = $urandom_range(0, 99);
    if (r < mdu_bias) f = tbl[$urandom_range(5, 8)];
    else if (r < mdu_bias + 6) o = 2'b00;
    else if (r < mdu_bias + 12) o = 2'b01;
    else if (r < mdu_bias + 18) o = 2'b11;
    do_op(s, o, f, pick_operand(), pick_operand());
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen_done;
    sel = 0; start = 1'b0; op = 2'b00; funct = 6'h00; a = '0; b = '0;
    for (int i = 0; i < 2; i++) begin
      m_hi[i] = 0; m_lo[i] = 0; m_res[i] = 0;
    end

    // Reset for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_result32", bus32.result, 32'd0);
    check("rst_hi32", bus32.hi, 32'd0);
    check("rst_lo32", bus32.lo, 32'd0);
    check("rst_zero32", 32'(bus32.zero), 32'd1);
    check("rst_done32", 32'(bus32.done), 32'd0);
    check("rst_busy32", 32'(bus32.busy), 32'd0);
    check("rst_result8", 32'(bus8.result), 32'd0);
    check("rst_zero8", 32'(bus8.zero), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // slt with -1 < 1, and across signed overflow
    do_op(0, 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1);
    check("slt_neg1", o_result, 32'd1);
    do_op(0, 2'b10, 6'h2A, 32'h8000_0000, 32'h7FFF_FFFF);
    check("slt_ovf", o_result, 32'd1);
    do_op(0, 2'b00, 6'h00, 32'hFFFF_FFFF, 32'd1);
    check("add_wrap", o_result, 32'd0);
    check("add_wrap_zero", 32'(o_zero), 32'd1);

    // mult / multu, then mflo straight from the done cycle
    do_op(0, 2'b10, 6'h18, 32'hFFFF_FFFD, 32'd7);
    check("mult_hi", o_hi, 32'hFFFF_FFFF);
    check("mult_lo", o_lo, 32'hFFFF_FFEB);
    do_op(0, 2'b10, 6'h19, 32'hFFFF_FFFD, 32'd7);
    check("multu_hi", o_hi, 32'h0000_0006);
    check("multu_lo", o_lo, 32'hFFFF_FFEB);
    do_op(0, 2'b10, 6'h12, 32'd0, 32'd0);
    check("mflo_b2b", o_result, 32'hFFFF_FFEB);

    // divide corner cases
    do_op(0, 2'b10, 6'h1A, 32'hFFFF_FFF9, 32'd2);
    check("div_lo", o_lo, 32'hFFFF_FFFD);
    check("div_hi", o_hi, 32'hFFFF_FFFF);
    do_op(0, 2'b10, 6'h1B, 32'd7, 32'd0);
    check("divu0_lo", o_lo, 32'hFFFF_FFFF);
    check("divu0_hi", o_hi, 32'd7);
    do_op(0, 2'b10, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf_lo", o_lo, 32'h8000_0000);
    check("divovf_hi", o_hi, 32'd0);
    do_op(0, 2'b10, 6'h1A, 32'hFFFF_FFF0, 32'd0);
    do_op(0, 2'b10, 6'h11, 32'h1234_5678, 32'd0);
    do_op(0, 2'b10, 6'h13, 32'h9ABC_DEF0, 32'd0);
    do_op(0, 2'b10, 6'h10, 32'd0, 32'd0);

    // mflo while busy is dropped
    sel = 0; start = 1'b1; op = 2'b10; funct = 6'h18; a = 32'd5; b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; funct = 6'h12;
    @(negedge clk);
    start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 60; i++) begin
      if (o_done) begin
        seen_done = 1;
        break;
      end
      @(negedge clk);
    end
    check("busy_run_done", 32'(seen_done), 32'd1);
    check("busy_mflo_dropped", o_result, m_res[0]);
    check("busy_mult_lo", o_lo, 32'd45);
    m_hi[0] = 0; m_lo[0] = 45;
    @(negedge clk);
    check("busy_no_late_done", 32'(o_done), 32'd0);
    check("busy_result_still", o_result, m_res[0]);

    // reset aborts a running divide
    sel = 0; start = 1'b1; op = 2'b10; funct = 6'h1A; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_hi", o_hi, 32'd0);
    check("abort_lo", o_lo, 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_result", o_result, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_done) seen_done = 1;
      @(negedge clk);
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    for (int i = 0; i < 2; i++) begin
      m_hi[i] = 0; m_lo[i] = 0; m_res[i] = 0;
    end

    // WIDTH=8 directed mult/div cases
    do_op(1, 2'b10, 6'h18, 32'hFD, 32'h07);
    check("w8_mult_hi", o_hi, 32'hFF);
    check("w8_mult_lo", o_lo, 32'hEB);
    do_op(1, 2'b10, 6'h1A, 32'h80, 32'hFF);
    check("w8_divovf_lo", o_lo, 32'h80);
    do_op(1, 2'b10, 6'h1A, 32'hF9, 32'h02);
    check("w8_div_hi", o_hi, 32'hFF);

    // randomized mix
    for (int i = 0; i < 300; i++) rand_op(1, 60);
    for (int i = 0; i < 150; i++) rand_op(0, 45);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
